// File: rtl/ram_sta_mirror_reader_if.sv
// ram_sta_mirror_reader_if: RAM read port plus output beat stream of the mirror reader.
interface ram_sta_mirror_reader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic                  m_last;

    modport master (
        output ram_rd_addr, m_valid, m_data, m_addr, m_last,
        input  ram_rd_data, m_ready
    );

    modport slave (
        input  ram_rd_addr, m_valid, m_data, m_addr, m_last,
        output ram_rd_data, m_ready
    );
endinterface

// File: rtl/ram_sta_mirror_reader.sv
// ram_sta_mirror_reader: sweeps a RAM address range and streams {data, addr, last} beats
// through a 2-entry FIFO, with credit-limited read issue for RAM latency 0 or 1.
module ram_sta_mirror_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 4,
    parameter int RAM_LAT    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    ram_sta_mirror_reader_if.master bus
);
    localparam int EW = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] next_addr, addr_q, infl_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  first, zero_done, issue, pop, wr_en, infl_v, infl_last, in_flight, credit, accept;
    logic [EW-1:0]         fifo [2];
    logic [EW-1:0]         wr_entry;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;

    assign accept      = state == IDLE && start && !abort;
    assign pop         = bus.m_valid && bus.m_ready;
    assign in_flight   = RAM_LAT != 0 && infl_v;
    // Credit counts the slot freed by this cycle's pop so a steady stream never bubbles.
    assign credit      = {1'b0, count} + {2'b0, in_flight} < 3'd2 + {2'b0, pop};
    assign wr_en       = RAM_LAT != 0 ? infl_v : issue;
    assign wr_entry    = RAM_LAT != 0 ? {infl_last, infl_addr, bus.ram_rd_data}
                                      : {remaining == ONE, next_addr, bus.ram_rd_data};
    assign bus.ram_rd_addr = issue ? next_addr : addr_q;
    assign bus.m_valid = count != 2'd0;
    assign {bus.m_last, bus.m_addr, bus.m_data} = fifo[rd_ptr];
    assign busy        = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        done    = zero_done;
        case (state)
            IDLE:    state_n = accept && len != '0 ? RUN : IDLE;
            RUN: begin
                // The first RUN cycle is idle so the first beat lands 2+RAM_LAT cycles after start.
                issue   = !first && credit;
                state_n = issue && remaining == ONE ? DRAIN : RUN;
            end
            DRAIN: begin
                done    = count == 2'd0 && !in_flight;
                state_n = done ? IDLE : DRAIN;
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            issue   = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first     <= 1'b0;
            zero_done <= 1'b0;
            next_addr <= '0;
            remaining <= '0;
            addr_q    <= '0;
            infl_v    <= 1'b0;
            infl_addr <= '0;
            infl_last <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
        end else begin
            first     <= accept && len != '0;
            zero_done <= accept && len == '0;
            addr_q    <= bus.ram_rd_addr;
            infl_v    <= issue;
            if (accept) begin
                next_addr <= start_addr;
                remaining <= len;
            end else if (issue) begin
                next_addr <= next_addr + ADDR_WIDTH'(1);
                remaining <= remaining - ONE;
            end
            if (issue) begin
                infl_addr <= next_addr;
                infl_last <= remaining == ONE;
            end
            if (abort) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (wr_en) begin
                    fifo[wr_ptr] <= wr_entry;
                    wr_ptr       <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, wr_en} - {1'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_ram_sta_mirror_reader.sv
// tb_ram_sta_mirror_reader: drives a RAM_LAT=0 and a RAM_LAT=1 reader with shared random stimulus
// and checks every beat against the expected address sequence and RAM contents.
module tb_ram_sta_mirror_reader;
    logic       clk = 0, rst_n = 0, start = 0, abort = 0, m_ready = 0;
    logic [3:0] start_addr = 0;
    logic [4:0] len = 0;
    logic       busy0, busy1, done0, done1;
    logic [3:0] mem [16];
    logic [3:0] rd1;
    int         cyc = 0, total = 0, bad = 0;
    bit         active = 0, full_ready = 0;
    int         exp_sa, exp_len;
    int         idx [2], done_cnt [2], done_cyc [2], first_v [2], last_pop [2];
    bit         stall [2];
    logic [8:0] held [2];

    ram_sta_mirror_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus0 ();
    ram_sta_mirror_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus1 ();

    ram_sta_mirror_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .RAM_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
        .abort(abort), .busy(busy0), .done(done0), .bus(bus0)
    );
    ram_sta_mirror_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
        .abort(abort), .busy(busy1), .done(done1), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd1 <= mem[bus1.ram_rd_addr];
    assign bus0.ram_rd_data = mem[bus0.ram_rd_addr];
    assign bus1.ram_rd_data = rd1;
    assign bus0.m_ready = m_ready;
    assign bus1.m_ready = m_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mon(input int i, input logic v, input logic r, input logic [3:0] d,
                       input logic [3:0] a, input logic l, input logic dn);
        int ea;
        if (!active) return;
        if (stall[i]) begin
            check($sformatf("hold_valid%0d", i), {31'd0, v}, 1);
            check($sformatf("hold_beat%0d", i), {23'd0, l, a, d}, {23'd0, held[i]});
        end
        if (v && r) begin
            ea = (exp_sa + idx[i]) % 16;
            if (idx[i] < exp_len) begin
                check($sformatf("addr%0d", i), {28'd0, a}, ea);
                check($sformatf("data%0d", i), {28'd0, d}, {28'd0, mem[ea]});
                check($sformatf("last%0d", i), {31'd0, l}, {31'd0, idx[i] == exp_len - 1});
            end else check($sformatf("extra_beat%0d", i), 1, 0);
            if (full_ready && idx[i] > 0) check($sformatf("gap%0d", i), cyc - last_pop[i], 1);
            last_pop[i] = cyc;
            idx[i]++;
        end
        if (v && first_v[i] < 0) first_v[i] = cyc;
        stall[i] = v && !r;
        held[i]  = {l, a, d};
        if (dn) begin
            done_cnt[i]++;
            done_cyc[i] = cyc;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.m_valid, bus0.m_ready, bus0.m_data, bus0.m_addr, bus0.m_last, done0);
        mon(1, bus1.m_valid, bus1.m_ready, bus1.m_data, bus1.m_addr, bus1.m_last, done1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_valid0", {31'd0, bus0.m_valid}, 0);
        check("rst_valid1", {31'd0, bus1.m_valid}, 0);
        check("rst_last0", {31'd0, bus0.m_last}, 0);
        check("rst_last1", {31'd0, bus1.m_last}, 0);
        check("rst_busy0", {31'd0, busy0}, 0);
        check("rst_busy1", {31'd0, busy1}, 0);
        check("rst_done0", {31'd0, done0}, 0);
        check("rst_done1", {31'd0, done1}, 0);
        check("rst_rdaddr0", {28'd0, bus0.ram_rd_addr}, 0);
        check("rst_rdaddr1", {28'd0, bus1.ram_rd_addr}, 0);
        check("rst_data0", {28'd0, bus0.m_data}, 0);
        check("rst_data1", {28'd0, bus1.m_data}, 0);
        check("rst_maddr0", {28'd0, bus0.m_addr}, 0);
        check("rst_maddr1", {28'd0, bus1.m_addr}, 0);
    endtask

    task automatic begin_sweep(input int sa, input int l, input bit full, output int s);
        exp_sa = sa; exp_len = l; full_ready = full; active = 1;
        for (int i = 0; i < 2; i++) begin
            idx[i] = 0; done_cnt[i] = 0; first_v[i] = -1; stall[i] = 0; last_pop[i] = 0; done_cyc[i] = -1;
        end
        start = 1; start_addr = 4'(sa); len = 5'(l);
        m_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        start = 0;
        s = cyc;
    endtask

    task automatic sweep(input int sa, input int l, input bit full, input bit poke);
        int s, n;
        begin_sweep(sa, l, full, s);
        for (n = 0; n < 400; n++) begin
            start = 0;
            if (idx[0] == l && idx[1] == l && done_cnt[0] > 0 && done_cnt[1] > 0 && !busy0 && !busy1) break;
            m_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            if (poke && busy0 && busy1 && $urandom_range(0, 7) == 0) begin
                start = 1; start_addr = 4'($urandom_range(0, 15)); len = 5'($urandom_range(1, 16));
            end
            step();
        end
        start = 0;
        check("timeout", {31'd0, n < 400}, 1);
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("beats%0d", i), idx[i], l);
            check($sformatf("done_once%0d", i), done_cnt[i], 1);
            if (l > 0) check($sformatf("latency%0d", i), first_v[i], s + 2 + i);
            else check($sformatf("zero_done_cyc%0d", i), done_cyc[i], s);
        end
        check("idle_busy0", {31'd0, busy0}, 0);
        check("idle_busy1", {31'd0, busy1}, 0);
    endtask

    task automatic abort_test();
        int s, n;
        begin_sweep(2, 10, 1, s);
        for (n = 0; n < 100; n++) begin
            if (idx[0] >= 2) break;
            step();
        end
        check("abort_reach", {31'd0, n < 100}, 1);
        abort = 1; start = 1; start_addr = 4'd9; len = 5'd5;
        step();
        abort = 0; start = 0;
        @(negedge clk);
        check("abort_valid0", {31'd0, bus0.m_valid}, 0);
        check("abort_valid1", {31'd0, bus1.m_valid}, 0);
        check("abort_busy0", {31'd0, busy0}, 0);
        check("abort_busy1", {31'd0, busy1}, 0);
        repeat (3) step();
        check("abort_idle0", {31'd0, busy0}, 0);
        check("abort_idle1", {31'd0, busy1}, 0);
        check("abort_nodone0", done_cnt[0], 0);
        check("abort_nodone1", done_cnt[1], 0);
        sweep(7, 5, 1, 0);
    endtask

    task automatic reset_test();
        int s;
        begin_sweep(4, 12, 0, s);
        repeat (6) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        active = 0;
        rst_n  = 0;
        #1;
        check_reset();
        check("rst_nodone0", done_cnt[0], 0);
        check("rst_nodone1", done_cnt[1], 0);
        step();
        rst_n = 1;
        sweep(9, 6, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(i);
        step();
        step();
        check_reset();
        rst_n = 1;
        sweep(3, 4, 1, 0);
        sweep(14, 4, 1, 0);
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
        sweep(0, 0, 1, 0);
        sweep(5, 16, 1, 0);
        repeat (3) sweep($urandom_range(0, 15), 8, 0, 0);
        sweep($urandom_range(0, 15), 16, 0, 1);
        abort_test();
        reset_test();
        repeat (6) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
            sweep($urandom_range(0, 15), $urandom_range(0, 16), 1'($urandom_range(0, 1)), 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ram_sta_mirror_reader.md
RAM_STA_MIRROR_READER -- requirements
Module: ram_sta_mirror_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: RAM address width, legal 4-10.
REQ-002 Parameter DATA_WIDTH, default 4: RAM word width, legal 1-256.
REQ-003 Parameter RAM_LAT, default 0: RAM read latency in clk cycles, legal 0 or 1, set equal to the attached RAM's OUT_REG.
REQ-004 clk  in  1: single clock, also drives the attached RAM's read clock.
REQ-005 rst_n  in  1: reset, asynchronous, active-low.
REQ-006 start  in  1: one-cycle request to begin a table sweep.
REQ-007 start_addr  in  ADDR_WIDTH: first RAM address to read.
REQ-008 len  in  ADDR_WIDTH+1: number of words to read, 0 to 2**ADDR_WIDTH.
REQ-009 abort  in  1: terminates the sweep immediately.
REQ-010 ram_rd_addr  out  ADDR_WIDTH: read address driven to the RAM.
REQ-011 ram_rd_data  in  DATA_WIDTH: read data returned by the RAM.
REQ-012 m_valid  out  1: output beat valid.
REQ-013 m_ready  in  1: downstream accepts the beat.
REQ-014 m_data  out  DATA_WIDTH: word read from the RAM.
REQ-015 m_addr  out  ADDR_WIDTH: RAM address the word was read from.
REQ-016 m_last  out  1: marks the final beat of the sweep.
REQ-017 busy  out  1: high while not IDLE.
REQ-018 done  out  1: one-cycle pulse when a sweep completes normally.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN.
REQ-020 IDLE -> RUN on start with len != 0: latch start_addr as next address, latch len as remaining count.
REQ-021 In IDLE, start with len == 0: no beats; done pulses on the following cycle; FSM stays in IDLE.
REQ-022 start is ignored while busy is high.
REQ-023 Buffering: a 2-entry output FIFO holds the captured {data, addr, last} beats.
REQ-024 RUN: issue one read per cycle when (FIFO occupancy + reads in flight) < 2; ram_rd_addr = next address; next address increments modulo 2**ADDR_WIDTH; remaining count decrements.
REQ-025 With RAM_LAT=0, ram_rd_data is captured in the issue cycle; with RAM_LAT=1, it is captured one cycle after issue, tagged with the issued address.
REQ-026 RUN -> DRAIN in the cycle the last read is issued.
REQ-027 DRAIN -> IDLE when the FIFO is empty and no read is in flight; done pulses in that same cycle.
REQ-028 m_valid = FIFO not empty; m_data, m_addr, and m_last come from the FIFO head; the head pops on m_valid && m_ready.
REQ-029 While m_valid is high and m_ready is low, m_data, m_addr, and m_last hold stable.
REQ-030 m_last is high only on the beat carrying the len-th word.
REQ-031 Latency: first m_valid asserts 2+RAM_LAT cycles after the edge that samples start.
REQ-032 Throughput: with m_ready held high, one beat per cycle with no bubbles, for both RAM_LAT values.
REQ-033 len = 2**ADDR_WIDTH reads every address exactly once, wrapping from 2**ADDR_WIDTH-1 to 0.
REQ-034 abort, in any state: next cycle FIFO is flushed, in-flight reads are discarded, FSM is in IDLE, m_valid is 0, and done does not pulse.
REQ-035 If abort and start coincide, abort wins and start is ignored.
REQ-036 ram_rd_addr holds its last value when no read is issued.

Reset
REQ-037 On rst_n low, asynchronously: FSM to IDLE, FIFO empty, in-flight tracking cleared.
REQ-038 Reset values: m_valid=0, m_last=0, busy=0, done=0, ram_rd_addr=0, m_data=0, m_addr=0.
REQ-039 Reset asserted mid-sweep aborts the sweep with no done pulse.
REQ-040 After rst_n deasserts, the first start is accepted on the first rising edge.

Verification
REQ-041 RAM_LAT=0, RAM preloaded mem[i]=i, start_addr=3, len=4, m_ready=1 -> beats addr 3,4,5,6 with data 3,4,5,6 on consecutive cycles; m_last on addr 6; done pulses once; busy low afterward.
REQ-042 RAM_LAT=1, ADDR_WIDTH=4, start_addr=14, len=4 -> beats in address order 14,15,0,1; first m_valid 3 cycles after start; no bubbles.
REQ-043 Backpressure: m_ready toggled 1,0,0,1 randomly during len=8 -> all 8 beats delivered in order with none dropped or duplicated, and data held stable while stalled.
REQ-044 len=0 start -> zero beats and a single done pulse one cycle later; len=16 (ADDR_WIDTH=4) -> all 16 addresses delivered.
REQ-045 abort asserted after the second beat of a len=10 sweep -> m_valid low next cycle, no done pulse, and a new start succeeds immediately.
REQ-046 rst_n pulsed low mid-sweep -> all outputs at their reset values asynchronously, and the next sweep is correct.
